// File: rtl/alu_cmd_issuer_if.sv
// Bundle of command, ALU-side and response signals between the issuer and its environment.
// The master modport is the issuer; the slave modport is the requester/ALU/consumer side.
interface alu_cmd_issuer_if #(
  parameter int WIDTH     = 16,
  parameter int ERR_CNT_W = 8
);
  logic                 CMD_VALID;
  logic                 CMD_READY;
  logic [WIDTH-1:0]     CMD_A;
  logic [WIDTH-1:0]     CMD_B;
  logic [3:0]           CMD_FUN;
  logic [WIDTH-1:0]     ALU_A;
  logic [WIDTH-1:0]     ALU_B;
  logic [3:0]           ALU_FUN;
  logic [WIDTH-1:0]     ALU_OUT;
  logic                 ARITH_FLAG;
  logic                 LOGIC_FLAG;
  logic                 CMP_FLAG;
  logic                 SHIFT_FLAG;
  logic                 RSP_VALID;
  logic                 RSP_READY;
  logic [WIDTH-1:0]     RSP_DATA;
  logic [3:0]           RSP_FLAGS;
  logic                 RSP_ERR;
  logic                 RSP_DZ;
  logic [15:0]          ISSUED_CNT;
  logic [ERR_CNT_W-1:0] ERR_CNT;

  modport master (
    input  CMD_VALID, CMD_A, CMD_B, CMD_FUN,
    input  ALU_OUT, ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG,
    input  RSP_READY,
    output CMD_READY, ALU_A, ALU_B, ALU_FUN,
    output RSP_VALID, RSP_DATA, RSP_FLAGS, RSP_ERR, RSP_DZ,
    output ISSUED_CNT, ERR_CNT
  );

  modport slave (
    output CMD_VALID, CMD_A, CMD_B, CMD_FUN,
    output ALU_OUT, ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG,
    output RSP_READY,
    input  CMD_READY, ALU_A, ALU_B, ALU_FUN,
    input  RSP_VALID, RSP_DATA, RSP_FLAGS, RSP_ERR, RSP_DZ,
    input  ISSUED_CNT, ERR_CNT
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Single-outstanding command initiator for the registered 16-bit ALU: issues operands,
// captures result and class flags, checks the class, intercepts divide-by-zero.
module alu_cmd_issuer #(
  parameter int WIDTH     = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  alu_cmd_issuer_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [3:0]           alu_fun_q, alu_fun_d;
  logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic [3:0]           rsp_flags_q, rsp_flags_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_dz_q, rsp_dz_d;
  logic [15:0]          issued_cnt_q, issued_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 cmd_ready;
  logic                 cmd_fire;
  logic                 div_zero;
  logic                 flag_mismatch;
  logic [3:0]           flags_in;
  logic [3:0]           exp_class;

  // Ready is masked by reset so nothing is accepted while reset is held.
  assign cmd_ready = (state_q == IDLE) && !RST;
  assign cmd_fire  = bus.CMD_VALID && cmd_ready;
  assign div_zero  = (bus.CMD_FUN == 4'b0011) && (bus.CMD_B == '0);
  assign flags_in  = {bus.ARITH_FLAG, bus.LOGIC_FLAG, bus.CMP_FLAG, bus.SHIFT_FLAG};
  assign flag_mismatch = (flags_in != exp_class);

  always_comb begin
    if (alu_fun_q <= 4'd3)       exp_class = 4'b1000;
    else if (alu_fun_q <= 4'd9)  exp_class = 4'b0100;
    else if (alu_fun_q <= 4'd12) exp_class = 4'b0010;
    else                         exp_class = 4'b0001;
  end

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_fun_d    = alu_fun_q;
    rsp_data_d   = rsp_data_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    rsp_dz_d     = rsp_dz_q;
    issued_cnt_d = issued_cnt_q;
    err_cnt_d    = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          alu_a_d = bus.CMD_A;
          alu_b_d = bus.CMD_B;
          if (div_zero) begin
            // Substitute an ADD so the ALU never sees a zero divisor.
            alu_fun_d   = 4'b0000;
            rsp_data_d  = '1;
            rsp_flags_d = 4'b0000;
            rsp_err_d   = 1'b0;
            rsp_dz_d    = 1'b1;
            state_d     = RESP;
          end else begin
            alu_fun_d = bus.CMD_FUN;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        issued_cnt_d = issued_cnt_q + 16'd1;
        state_d      = CAPTURE;
      end
      CAPTURE: begin
        rsp_data_d  = bus.ALU_OUT;
        rsp_flags_d = flags_in;
        rsp_dz_d    = 1'b0;
        rsp_err_d   = flag_mismatch;
        if (flag_mismatch && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.RSP_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_fun_q    <= '0;
      rsp_data_q   <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_dz_q     <= 1'b0;
      issued_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_fun_q    <= alu_fun_d;
      rsp_data_q   <= rsp_data_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      rsp_dz_q     <= rsp_dz_d;
      issued_cnt_q <= issued_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.CMD_READY  = cmd_ready;
  assign bus.ALU_A      = alu_a_q;
  assign bus.ALU_B      = alu_b_q;
  assign bus.ALU_FUN    = alu_fun_q;
  assign bus.RSP_VALID  = (state_q == RESP);
  assign bus.RSP_DATA   = rsp_data_q;
  assign bus.RSP_FLAGS  = rsp_flags_q;
  assign bus.RSP_ERR    = rsp_err_q;
  assign bus.RSP_DZ     = rsp_dz_q;
  assign bus.ISSUED_CNT = issued_cnt_q;
  assign bus.ERR_CNT    = err_cnt_q;

endmodule
